// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-and-add multiplier.
// Optional build macro: MUL_SIGNED_EN (enables signed operation select).
package mul_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // 2'b11 is not listed; it behaves like MUL_UU.
  typedef enum logic [1:0] {
    MUL_UU = 2'b00,
    MUL_SS = 2'b01,
    MUL_SU = 2'b10
  } op_t;

endpackage

// File: rtl/mul_step.sv
// One shift-and-add iteration: adds A times the current multiplier chunk,
// shifted into its bit position, onto the 64-bit accumulator.
// Optional build macro: MUL_SIGNED_EN (not used in this file).
module mul_step
  import mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [2*XLEN-1:0]         acc,
  input  logic [XLEN-1:0]           a,
  input  logic [BITS_PER_CYCLE-1:0] b_chunk,
  input  logic [5:0]                shift,
  output logic [2*XLEN-1:0]         acc_next
);

  logic [2*XLEN-1:0] partial;

  // Zero-extended partial product, shifted and added; never overflows 64 bits.
  always_comb begin
    partial  = {{XLEN{1'b0}}, a} * {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, b_chunk};
    acc_next = acc + (partial << shift);
  end

endmodule

// File: rtl/multiplier_unsigned_multicycle.sv
// Iterative 32x32->64 shift-and-add multiplier with valid/ready handshakes
// on both sides. Retires BITS_PER_CYCLE multiplier bits per clock.
// Optional build macro: MUL_SIGNED_EN (latches i_op and applies sign handling).
module multiplier_unsigned_multicycle
  import mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_multiplicand,
  input  logic [XLEN-1:0] i_multiplier,
  input  logic [1:0]      i_op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_product_lo,
  output logic [XLEN-1:0] o_product_hi
);

  localparam int         ITER     = XLEN / BITS_PER_CYCLE;
  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
        BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bits_per_cycle
    $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_t            state, state_next;
  logic [2*XLEN-1:0] acc, acc_next, result;
  logic [XLEN-1:0]   a_reg, b_reg;
  logic [XLEN-1:0]   a_in, b_in;
  logic [5:0]        cnt, shift;
  logic              accept, last_iter;

  assign accept    = i_valid && o_ready;
  assign last_iter = (cnt == LAST_CNT);
  assign shift     = 6'(cnt * BITS_PER_CYCLE);

`ifdef MUL_SIGNED_EN
  logic sign_a, sign_b, neg_in, neg_reg;

  // Operands become magnitudes at acceptance; the sign is reapplied at the end.
  always_comb begin
    sign_a = ((i_op == MUL_SS) || (i_op == MUL_SU)) && i_multiplicand[XLEN-1];
    sign_b = (i_op == MUL_SS) && i_multiplier[XLEN-1];
    a_in   = sign_a ? -i_multiplicand : i_multiplicand;
    b_in   = sign_b ? -i_multiplier : i_multiplier;
    neg_in = sign_a ^ sign_b;
  end

  // Negate flag captured alongside the operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_reg <= 1'b0;
    end else if (state == IDLE && accept) begin
      neg_reg <= neg_in;
    end
  end

  assign result = neg_reg ? -acc_next : acc_next;
`else
  logic unused_op;
  assign unused_op = ^i_op;
  assign a_in      = i_multiplicand;
  assign b_in      = i_multiplier;
  assign result    = acc_next;
`endif

  mul_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc     (acc),
    .a       (a_reg),
    .b_chunk (b_reg[BITS_PER_CYCLE-1:0]),
    .shift   (shift),
    .acc_next(acc_next)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands, iterate, and register the final product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      acc          <= '0;
      cnt          <= '0;
      o_product_lo <= '0;
      o_product_hi <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a_in;
            b_reg <= b_in;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          b_reg <= b_reg >> BITS_PER_CYCLE;
          cnt   <= cnt + 6'd1;
          if (last_iter) begin
            o_product_lo <= result[XLEN-1:0];
            o_product_hi <= result[2*XLEN-1:XLEN];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_unsigned_multicycle.sv
// Self-checking bench for multiplier_unsigned_multicycle: directed cases,
// backpressure, busy-time operand rejection, mid-operation reset, and
// randomized operands against an arithmetic reference product.
// Optional build macro: MUL_SIGNED_EN (adds signed-operation cases).
module tb_multiplier_unsigned_multicycle;

  localparam int BPC  = 4;
  localparam int ITER = 32 / BPC;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_multiplicand;
  logic [31:0] i_multiplier;
  logic [1:0]  i_op;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_product_lo;
  logic [31:0] o_product_hi;

  int tests = 0;
  int fails = 0;

  multiplier_unsigned_multicycle #(
    .BITS_PER_CYCLE(BPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_multiplicand(i_multiplicand),
    .i_multiplier  (i_multiplier),
    .i_op          (i_op),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_product_lo  (o_product_lo),
    .o_product_hi  (o_product_hi)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  // Reference: operands widened to 64 bits per operation, product modulo 2^64.
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
    logic [63:0] wa, wb;
    wa = {32'b0, a};
    wb = {32'b0, b};
`ifdef MUL_SIGNED_EN
    if (op == 2'b01) begin
      wa = {{32{a[31]}}, a};
      wb = {{32{b[31]}}, b};
    end else if (op == 2'b10) begin
      wa = {{32{a[31]}}, a};
    end
`else
    if (op == 2'b11) wa = {32'b0, a};
`endif
    return wa * wb;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for o_ready, then presents operands for one accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int n;
    n = 0;
    while (!o_ready && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ready_before_accept", 64'(o_ready), 64'd1);
    i_valid        = 1'b1;
    i_multiplicand = a;
    i_multiplier   = b;
    i_op           = op;
    @(posedge clk); #1;
    i_valid        = 1'b0;
    i_multiplicand = $urandom;
    i_multiplier   = $urandom;
  endtask

  // Counts edges after acceptance until o_valid appears (bounded).
  task automatic waitResult(input int start, output int lat);
    lat = start;
    while (!o_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One full transaction with optional result backpressure.
  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input int hold);
    logic [63:0] exp;
    int lat;
    exp     = refProduct(a, b, op);
    i_ready = (hold == 0);
    applyStimulus(a, b, op);
    waitResult(0, lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(ITER));
    checkOutput({tag, "_product"}, {o_product_hi, o_product_lo}, exp);
    for (int i = 0; i < hold; i++) begin
      checkOutput({tag, "_hold_hs"}, 64'({o_valid, o_ready}), 64'(2'b10));
      checkOutput({tag, "_hold_prod"}, {o_product_hi, o_product_lo}, exp);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, "_after_hs"}, 64'({o_valid, o_ready}), 64'(2'b01));
    checkOutput({tag, "_idle_prod"}, {o_product_hi, o_product_lo}, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int          lat;
    logic        seen;

    rst            = 1'b0;
    i_valid        = 1'b0;
    i_ready        = 1'b1;
    i_multiplicand = '0;
    i_multiplier   = '0;
    i_op           = 2'b00;

    // Reset state
    #3;
    checkOutput("reset_ready", 64'(o_ready), 64'd1);
    checkOutput("reset_valid", 64'(o_valid), 64'd0);
    checkOutput("reset_product", {o_product_hi, o_product_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    runOp("mul_7x6", 32'd7, 32'd6, 2'b00, 0);
    checkOutput("mul_7x6_lo", 64'(o_product_lo), 64'h2A);
    runOp("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 0);
    checkOutput("mul_max_hi", 64'(o_product_hi), 64'hFFFF_FFFE);
    runOp("mul_a_zero", 32'd0, $urandom, 2'b00, 0);
    runOp("mul_b_zero", $urandom, 32'd0, 2'b00, 0);
    runOp("backpressure", 32'h1_0000, 32'h1_0000, 2'b00, 5);
    checkOutput("backpressure_hi", 64'(o_product_hi), 64'h1);

    // Operands presented while busy must be ignored
    i_ready = 1'b1;
    applyStimulus(32'd5, 32'd3, 2'b00);
    repeat (3) begin @(posedge clk); #1; end
    i_valid        = 1'b1;
    i_multiplicand = 32'd9;
    i_multiplier   = 32'd9;
    @(posedge clk); #1;
    i_valid = 1'b0;
    waitResult(4, lat);
    checkOutput("busy_ignore_latency", 64'(lat), 64'(ITER));
    checkOutput("busy_ignore_product", {o_product_hi, o_product_lo}, 64'd15);
    @(posedge clk); #1;
    seen = 1'b0;
    for (int i = 0; i < 2 * ITER; i++) begin
      seen |= o_valid;
      @(posedge clk); #1;
    end
    checkOutput("busy_ignore_no_second", 64'(seen), 64'd0);

    // Reset during the busy phase aborts the operation
    applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 2'b00);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checkOutput("abort_valid", 64'(o_valid), 64'd0);
    checkOutput("abort_ready", 64'(o_ready), 64'd1);
    checkOutput("abort_product", {o_product_hi, o_product_lo}, 64'd0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 * ITER; i++) begin
      @(posedge clk); #1;
      seen |= o_valid;
    end
    checkOutput("abort_no_result", 64'(seen), 64'd0);

`ifdef MUL_SIGNED_EN
    runOp("signed_ss", 32'hFFFF_FFFD, 32'd5, 2'b01, 0);
    runOp("signed_su", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 0);
    runOp("signed_ss_min", 32'h8000_0000, 32'h8000_0000, 2'b01, 0);
    runOp("signed_op11", 32'hFFFF_FFFF, 32'd2, 2'b11, 0);
`endif

    // Randomized operands, op and backpressure
    for (int i = 0; i < 20; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 2'($urandom_range(0, 3));
      if (i % 5 == 0) ra = 32'hFFFF_FFFF;
      if (i % 7 == 0) rb = 32'h8000_0000;
      runOp("random", ra, rb, rop, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
